// File: rtl/alu_io_pkg.sv
// Shared types and constants for the push-button debouncer.
//   db_state_t       : 2-bit encoding of the four debounce FSM states
//   DEBOUNCE_DEFAULT : default stable-sample count (10 ms at 50 MHz)
package alu_io_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous level into the clk domain.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input level
//   q     : synchronized output, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes btn_raw, requires DEBOUNCE_CYCLES
// consecutive stable samples before accepting a level change, and emits a
// one-cycle press_pulse on each accepted press.
// Ports:
//   clk           : clock
//   rst_n         : asynchronous active-low reset
//   btn_raw       : raw button level (asynchronous, high = pressed)
//   btn_db        : registered debounced level
//   press_pulse   : one-cycle pulse in the first cycle btn_db is high
//   release_pulse : one-cycle pulse in the first cycle btn_db is low after a
//                   qualified release (only when BTN_RELEASE_PULSE_EN is defined)
// Build option: BTN_RELEASE_PULSE_EN adds the release_pulse port and logic.
//
// state         | meaning
// --------------+---------------------------------------------------------
// S_RELEASED    | button accepted as released, waiting for sync=1
// S_PRESS_CHK   | sync went high, counting stable high samples
// S_PRESSED     | button accepted as pressed, waiting for sync=0
// S_RELEASE_CHK | sync went low, counting stable low samples (btn_db still 1)
module button_debounce
  import alu_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db,
`ifdef BTN_RELEASE_PULSE_EN
  output logic release_pulse,
`endif
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             press_q, press_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RELEASED;
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
      press_q  <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RELEASED: begin
        if (sync) begin
          state_d = S_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!sync) begin
          state_d = S_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!sync) begin
          state_d = S_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      S_RELEASE_CHK: begin
        if (sync) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RELEASED;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register, not one cycle later.
  always_comb begin
    btn_db_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_CHK);
    // Only a qualified press enters S_PRESSED from S_PRESS_CHK; a bounce
    // returning from S_RELEASE_CHK must not pulse again.
    press_d  = (state_q == S_PRESS_CHK) && (state_d == S_PRESSED);
  end

  assign btn_db      = btn_db_q;
  assign press_pulse = press_q;

`ifdef BTN_RELEASE_PULSE_EN
  logic release_q, release_d;

  always_comb begin
    release_d = (state_q == S_RELEASE_CHK) && (state_d == S_RELEASED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end

  assign release_pulse = release_q;
`endif

endmodule
